// File: rtl/btn_cond_pkg.sv
// Shared types and default timing for the push-button conditioner.
// Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package btn_cond_pkg;

    // Auto-repeat controller states, one FSM per channel.
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_RUN
    } rpt_state_t;

    // Defaults sized for a 100 MHz system clock.
    localparam int unsigned DEF_N_CH            = 5;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000;
    localparam int unsigned DEF_REPEAT_PERIOD   = 10_000_000;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, counter debouncer, registered press/release
// pulses and, when BTN_AUTOREPEAT_EN is defined, an auto-repeat pulse generator.
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          ff1_q, ff2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    // Bring the raw asynchronous level into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= btn_in;
            ff2_q <= ff1_q;
        end
    end

    // Count consecutive samples that differ from the stable level; any reversion restarts.
    always_comb begin
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (ff2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d  = ff2_q;
            cnt_d     = '0;
            press_d   = ff2_q;
            release_d = ~ff2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Level and its edge pulse update on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q  <= 1'b0;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = stable_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned   RPT_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                          : REPEAT_PERIOD;
    localparam int unsigned   RW         = $clog2(RPT_MAX) + 1;
    localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

    rpt_state_t    rpt_state_q, rpt_state_d;
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic          rpt_q, rpt_d;

    // Repeat FSM next-state: a release (or an unpressed level) wins over any due repeat.
    always_comb begin
        rpt_state_d = rpt_state_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_d       = 1'b0;
        if (press_d) begin
            rpt_state_d = RPT_DELAY;
            rpt_cnt_d   = DELAY_LOAD;
        end else if (release_d || !stable_q) begin
            rpt_state_d = RPT_IDLE;
            rpt_cnt_d   = '0;
        end else begin
            unique case (rpt_state_q)
                RPT_DELAY, RPT_RUN: begin
                    if (rpt_cnt_q == '0) begin
                        rpt_d       = 1'b1;
                        rpt_state_d = RPT_RUN;
                        rpt_cnt_d   = PERIOD_LOAD;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q - RW'(1);
                    end
                end
                default: begin
                    rpt_state_d = RPT_IDLE;
                end
            endcase
        end
    end

    // Repeat FSM state, counter and registered pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_state_q <= RPT_IDLE;
            rpt_cnt_q   <= '0;
            rpt_q       <= 1'b0;
        end else begin
            rpt_state_q <= rpt_state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_q       <= rpt_d;
        end
    end

    assign btn_repeat = rpt_q;
`else
    // Repeat timing is irrelevant without the feature; fold it into a deliberately unused net.
    logic unused_rpt_cfg;
    assign unused_rpt_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
    assign btn_repeat     = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// N-channel push-button front end: independent debounced channels plus an any-press OR.
// Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN; otherwise btn_repeat is tied to 0.
module btn_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned N_CH            = DEF_N_CH,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat,
    output logic            any_press
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .btn_in     (btn_in[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

    assign any_press = |btn_press;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing (debounce 4, repeat 10/3).
// Repeat checks are compiled in when BTN_AUTOREPEAT_EN is defined.
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn_in;
    logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
    logic       any_press;
    logic       seen_rpt = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    btn_conditioner #(
        .N_CH           (5),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat),
        .any_press  (any_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) seen_rpt <= seen_rpt | (|btn_repeat);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_level"}, 32'(btn_level), 32'h0);
        chk({tag, "_press"}, 32'(btn_press), 32'h0);
        chk({tag, "_release"}, 32'(btn_release), 32'h0);
        chk({tag, "_repeat"}, 32'(btn_repeat), 32'h0);
        chk({tag, "_any"}, 32'(any_press), 32'h0);
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 5'h00;
        step(2);
        chk_all_zero("in_reset");
        reset = 1'b0;
        step(2);
        chk_all_zero("after_reset");

        // Test 1: qualify all buttons, then reset mid-cycle while held.
        btn_in = 5'h1F;
        step(8);
        chk("t1_level_held", 32'(btn_level), 32'h1F);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("t1_async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("t1_press", 32'(btn_press), (k == 6) ? 32'h1F : 32'h0);
            chk("t1_any", 32'(any_press), 32'(k == 6));
            chk("t1_level", 32'(btn_level), (k >= 6) ? 32'h1F : 32'h0);
        end
        btn_in = 5'h00;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("t1_release", 32'(btn_release), (k == 6) ? 32'h1F : 32'h0);
            chk("t1_rel_nopress", 32'(btn_press), 32'h0);
        end

        // Test 2: single-channel press, held, then released.
        btn_in = 5'h01;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("t2_press0", 32'(btn_press[0]), 32'(k == 6));
            chk("t2_level0", 32'(btn_level[0]), 32'(k >= 6));
        end
        step(13);
        chk("t2_hold_level", 32'(btn_level), 32'h01);
        chk("t2_hold_press", 32'(btn_press), 32'h0);
        btn_in = 5'h00;
        step(8);
        chk("t2_released", 32'(btn_level), 32'h0);

        // Test 3a: a 3-cycle glitch is rejected.
        btn_in = 5'h02;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            chk("t3_glitch_press", 32'(btn_press[1]), 32'h0);
            chk("t3_glitch_level", 32'(btn_level[1]), 32'h0);
            chk("t3_glitch_rel", 32'(btn_release[1]), 32'h0);
            if (k == 3) btn_in = 5'h00;
        end
        // Test 3b: exactly 4 cycles is just enough, followed by a qualified release.
        btn_in = 5'h02;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk("t3_edge_press", 32'(btn_press[1]), 32'(k == 6));
            chk("t3_edge_rel", 32'(btn_release[1]), 32'(k == 10));
            chk("t3_edge_level", 32'(btn_level[1]), 32'(k >= 6 && k < 10));
            if (k == 4) btn_in = 5'h00;
        end

        // Test 4: bouncing input yields a single press after the last toggle.
        for (int seg = 0; seg < 6; seg++) begin
            btn_in[2] = (seg % 2 == 0);
            for (int j = 0; j < 2; j++) begin
                step(1);
                chk("t4_bounce_press", 32'(btn_press[2]), 32'h0);
                chk("t4_bounce_level", 32'(btn_level[2]), 32'h0);
            end
        end
        btn_in[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("t4_press2", 32'(btn_press[2]), 32'(k == 6));
            chk("t4_level2", 32'(btn_level[2]), 32'(k >= 6));
        end

        // Test 5: simultaneous presses on channels 0 and 3 (channel 2 still held).
        btn_in = 5'b01101;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            chk("t5_press", 32'(btn_press), (k == 6) ? 32'h09 : 32'h0);
            chk("t5_any", 32'(any_press), 32'(k == 6));
        end
        btn_in = 5'h00;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            chk("t5_release", 32'(btn_release), (k == 6) ? 32'h0D : 32'h0);
        end
        chk("t5_level_idle", 32'(btn_level), 32'h0);

`ifdef BTN_AUTOREPEAT_EN
        // Test 6: repeats at press+10 then every 3; release cancels the repeat due with it.
        btn_in = 5'h01;
        for (int k = 1; k <= 42; k++) begin
            step(1);
            chk("t6_repeat0", 32'(btn_repeat[0]),
                32'(k >= 16 && k <= 34 && (k - 16) % 3 == 0));
            chk("t6_release0", 32'(btn_release[0]), 32'(k == 37));
            chk("t6_press0", 32'(btn_press[0]), 32'(k == 6));
            if (k == 31) btn_in = 5'h00;
        end
`else
        // Test 6: without auto-repeat, a long hold never produces a repeat pulse.
        btn_in = 5'h01;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            chk("t6_norepeat", 32'(btn_repeat), 32'h0);
        end
        btn_in = 5'h00;
        step(8);
        chk("t6_never_repeated", 32'(seen_rpt), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
